muldiv_ctrl: RTL and testbench
==============================

# muldiv_ctrl

Sequencer and result buffer in front of the execute stage's iterative multiplier and divider. It accepts one RV64M operation at a time over a valid/ready handshake and latches its operands. It normalises signed and word operands for the unsigned sub-units, sequences the chosen sub-unit to completion, and applies sign and width fix-up. It resolves divide-by-zero and signed overflow without starting the divider, and holds the result until the consumer accepts it. It also handles pipeline flushes safely while a sub-unit is busy.

## Interface
Parameters:
- XLEN, 64, datapath width; the word ops operate on bits [31:0].

Ports:
- clk  in  1  clock, all state on the rising edge.
- reset  in  1  asynchronous, active-low (0 = reset).
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  operation: 0 MUL, 1 MULW, 2 DIV, 3 DIVU, 4 REM, 5 REMU, 6 DIVW, 7 DIVUW, 8 REMW, 9 REMUW; 10-15 illegal.
- req_a, req_b  in  XLEN  rs1 and rs2 values.
- flush  in  1  kill the in-flight op or the held result.
- resp_valid  out  1  result held in resp_data.
- resp_ready  in  1  consumer accepts.
- resp_data  out  XLEN  result.
- mul_valid  out  1  held high while the multiplier is running.
- mul_a, mul_b  out  XLEN  multiplier operands.
- mul_done  in  1  multiplier finished.
- mul_c  in  2*XLEN  multiplier product.
- div_valid  out  1  held high while the divider is running.
- div_word  out  1  32-bit divide.
- div_a, div_b  out  XLEN  unsigned dividend and divisor.
- div_done  in  1  divider finished.
- div_c  in  2*XLEN  {remainder, quotient}, both unsigned.

## Operation
States: IDLE, MUL, DIV, DONE, ABORT.

Accept (IDLE):
- An op is accepted when req_valid and req_ready are both high.
- On accept, latch op, a, b, sa = sign of a, sb = sign of b. The sign is bit 63, or bit 31 for word ops; it is 0 for unsigned ops.
- Next state:
  - MUL, for ops 0-1.
  - DONE, for the bypass cases: b == 0 (bits [31:0] only for word ops), signed overflow, or an illegal op. The result is latched directly.
  - DIV, for all other divide and remainder ops.

Bypass results:
- Divide by zero: quotient = all ones; remainder = a. For word ops the remainder is sext(a[31:0]).
- Signed overflow is a = most-negative value and b = -1, for DIV/REM or DIVW/REMW. Quotient = a (word: sext(a[31:0])); remainder = 0.
- Illegal op: result 0.

MUL state:
- mul_a and mul_b come from the latched operands.
- mul_valid stays high until mul_done.
- On done: MUL takes mul_c[63:0]; MULW takes sext(mul_c[31:0]). Go to DONE.

DIV state:
- div_a = |a| and div_b = |b| when signed; the word forms are zero-extended magnitudes of the low 32 bits.
- div_word = op is 6-9.
- div_valid stays high until div_done.
- Fix-up on done:
  - The quotient is negated if sa != sb.
  - The remainder is negated if sa.
  - Word results are sext of bits [31:0] after fix-up.
  - DIV* selects the quotient and REM* selects the remainder. Go to DONE.

DONE:
- resp_valid = 1.
- The transfer is resp_valid & resp_ready, then go to IDLE.

ABORT:
- The sub-unit's valid stays high until its done, so the sub-unit always terminates cleanly.
- The result is discarded, then go to IDLE. resp_valid is 0 throughout.

Flush:
- In MUL or DIV: go to ABORT, except when done arrives in the same cycle, in which case go straight to IDLE and discard the result.
- In DONE: go to IDLE and drop the result, even if resp_ready is high.
- In IDLE: no request is accepted that cycle.
- In ABORT: no effect.

## Timing
- Reset values: state IDLE, req_ready 1, resp_valid 0, resp_data 0, mul_valid 0, div_valid 0, div_word 0, all operand outputs 0.
- Reset asserted mid-operation forces IDLE immediately. The sub-units share the same reset.
- The sub-unit valids are asserted starting the cycle after accept.
- Sampling done at edge k latches the result; resp_valid rises at cycle k+1.
- Latency from accept to resp_valid:
  - Bypass cases: 1 cycle.
  - Sub-unit ops: N+1 cycles, where N is the number of cycles from the valid rising to done.
- There is no back-to-back issue: req_ready is low from the cycle after accept until the cycle after the response transfers or the abort finishes.
- resp_data is stable while resp_valid is high and resp_ready is low.
- The operand outputs are combinational from the latched registers and are stable for the whole MUL or DIV or ABORT period.
- done is ignored outside the matching MUL/DIV/ABORT state.

## Test plan
- **DIV sign fix-up:** DIV a=-7, b=2, divider returns {1,3} → resp_data -3. REM with the same operands → resp_data -1. DIVU a=7, b=2 → 3.
- **MULW sign extension:** MULW a=0x7FFF_FFFF, b=2, mul_c low = 0xFFFF_FFFE → resp_data 0xFFFF_FFFF_FFFF_FFFE. MUL 3×5 → 15.
- **Bypass cases:**
  - DIV x/0 → resp_data all ones, 1 cycle after accept, div_valid never high.
  - REMW a=0x1_8000_0005, b=0 → 0xFFFF_FFFF_8000_0005.
  - DIV 0x8000_0000_0000_0000 / -1 → 0x8000_0000_0000_0000.
  - REM of the same operands → 0.
- **Backpressure:** resp_ready held low for 5 cycles → resp_valid and resp_data stable, req_ready 0. Raising resp_ready → one transfer, then req_ready 1 on the next cycle.
- **Flush mid-divide:** flush 3 cycles into DIV → div_valid stays high until div_done, resp_valid never rises, then req_ready returns. The next request DIVU 9/3 → 3.
- **Reset and flush edges:**
  - reset low during MUL → all outputs at reset values asynchronously.
  - flush in DONE together with resp_ready → no transfer is counted.

Source files
------------

// File: rtl/muldiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl
// Description : RV64M sequencer and result buffer in front of the iterative
//               multiplier and divider. Latches one op, normalises operands
//               for the unsigned sub-units, resolves divide-by-zero and signed
//               overflow locally, applies sign/width fix-up and holds the
//               result until the consumer takes it. Flush-safe while busy.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [3:0]          req_op,
    input  logic [XLEN-1:0]     req_a,
    input  logic [XLEN-1:0]     req_b,
    input  logic                flush,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [XLEN-1:0]     resp_data,
    output logic                mul_valid,
    output logic [XLEN-1:0]     mul_a,
    output logic [XLEN-1:0]     mul_b,
    input  logic                mul_done,
    input  logic [2*XLEN-1:0]   mul_c,
    output logic                div_valid,
    output logic                div_word,
    output logic [XLEN-1:0]     div_a,
    output logic [XLEN-1:0]     div_b,
    input  logic                div_done,
    input  logic [2*XLEN-1:0]   div_c
);

    localparam logic [3:0] c_op_mul   = 4'd0;
    localparam logic [3:0] c_op_mulw  = 4'd1;
    localparam logic [3:0] c_op_div   = 4'd2;
    localparam logic [3:0] c_op_divu  = 4'd3;
    localparam logic [3:0] c_op_rem   = 4'd4;
    localparam logic [3:0] c_op_remu  = 4'd5;
    localparam logic [3:0] c_op_divw  = 4'd6;
    localparam logic [3:0] c_op_divuw = 4'd7;
    localparam logic [3:0] c_op_remw  = 4'd8;
    localparam logic [3:0] c_op_remuw = 4'd9;

    localparam logic [XLEN-1:0] c_xlen_min = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_MUL   = 3'd1,
        S_DIV   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [3:0]         r_op;
    logic [XLEN-1:0]    r_a;
    logic [XLEN-1:0]    r_b;
    logic               r_sa;
    logic               r_sb;
    logic [XLEN-1:0]    r_resp_data;

    logic               w_load;
    logic [XLEN-1:0]    w_load_data;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] x);
        return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

    // ------------------------------------------------------------------
    // Request-side decode (on the incoming op, used only at accept)
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_req_is_mul;
    logic               w_req_illegal;
    logic               w_req_word;
    logic               w_req_signed;
    logic               w_req_is_rem;
    logic               w_req_sa;
    logic               w_req_sb;
    logic               w_req_b_zero;
    logic               w_req_ovf;
    logic               w_req_bypass;
    logic [XLEN-1:0]    w_bypass_data;

    assign w_accept      = req_valid && req_ready && !flush;
    assign w_req_is_mul  = (req_op == c_op_mul) || (req_op == c_op_mulw);
    assign w_req_illegal = (req_op > c_op_remuw);
    assign w_req_word    = (req_op == c_op_mulw) ||
                           ((req_op >= c_op_divw) && (req_op <= c_op_remuw));
    assign w_req_signed  = (req_op == c_op_div)  || (req_op == c_op_rem) ||
                           (req_op == c_op_divw) || (req_op == c_op_remw);
    assign w_req_is_rem  = (req_op == c_op_rem)  || (req_op == c_op_remu) ||
                           (req_op == c_op_remw) || (req_op == c_op_remuw);
    assign w_req_sa      = w_req_signed && (w_req_word ? req_a[31] : req_a[XLEN-1]);
    assign w_req_sb      = w_req_signed && (w_req_word ? req_b[31] : req_b[XLEN-1]);
    assign w_req_b_zero  = w_req_word ? (req_b[31:0] == 32'd0) : (req_b == '0);
    assign w_req_ovf     = w_req_signed &&
                           (w_req_word ? ((req_a[31:0] == 32'h8000_0000) && (req_b[31:0] == 32'hFFFF_FFFF))
                                       : ((req_a == c_xlen_min) && (&req_b)));
    // Multiplies never bypass: a zero multiplier operand is just a normal product
    assign w_req_bypass  = w_req_illegal || (!w_req_is_mul && (w_req_b_zero || w_req_ovf));

    // Result for the cases resolved without starting the divider
    always_comb begin
        w_bypass_data = '0;
        if (w_req_illegal) begin
            w_bypass_data = '0;
        end else if (w_req_b_zero) begin
            if (w_req_is_rem)
                w_bypass_data = w_req_word ? sext32(req_a) : req_a;
            else
                w_bypass_data = '1;
        end else if (w_req_ovf) begin
            if (w_req_is_rem)
                w_bypass_data = '0;
            else
                w_bypass_data = w_req_word ? sext32(req_a) : req_a;
        end
    end

    // ------------------------------------------------------------------
    // Latched-op decode and sub-unit operand / result shaping
    // ------------------------------------------------------------------
    logic               w_op_is_mul;
    logic               w_op_div_word;
    logic               w_op_is_rem;
    logic [31:0]        w_a_lo_mag;
    logic [31:0]        w_b_lo_mag;
    logic [XLEN-1:0]    w_a_mag;
    logic [XLEN-1:0]    w_b_mag;
    logic [XLEN-1:0]    w_mul_result;
    logic [XLEN-1:0]    w_quo_fix;
    logic [XLEN-1:0]    w_rem_fix;
    logic [XLEN-1:0]    w_div_sel;
    logic [XLEN-1:0]    w_div_result;
    logic               w_unused;

    assign w_op_is_mul   = (r_op == c_op_mul) || (r_op == c_op_mulw);
    assign w_op_div_word = (r_op >= c_op_divw) && (r_op <= c_op_remuw);
    assign w_op_is_rem   = (r_op == c_op_rem)  || (r_op == c_op_remu) ||
                           (r_op == c_op_remw) || (r_op == c_op_remuw);

    // Signs are zero for unsigned ops, so these reduce to plain pass-through
    assign w_a_lo_mag = r_sa ? (32'd0 - r_a[31:0]) : r_a[31:0];
    assign w_b_lo_mag = r_sb ? (32'd0 - r_b[31:0]) : r_b[31:0];
    assign w_a_mag    = w_op_div_word ? {{(XLEN-32){1'b0}}, w_a_lo_mag} : (r_sa ? -r_a : r_a);
    assign w_b_mag    = w_op_div_word ? {{(XLEN-32){1'b0}}, w_b_lo_mag} : (r_sb ? -r_b : r_b);

    assign w_mul_result = (r_op == c_op_mulw) ? sext32(mul_c[XLEN-1:0]) : mul_c[XLEN-1:0];

    // Full-width negation also gives the correct low word for the W forms
    assign w_quo_fix    = (r_sa ^ r_sb) ? -div_c[XLEN-1:0]      : div_c[XLEN-1:0];
    assign w_rem_fix    = r_sa          ? -div_c[2*XLEN-1:XLEN] : div_c[2*XLEN-1:XLEN];
    assign w_div_sel    = w_op_is_rem ? w_rem_fix : w_quo_fix;
    assign w_div_result = w_op_div_word ? sext32(w_div_sel) : w_div_sel;

    // The high product half is never needed for MUL/MULW
    assign w_unused = ^mul_c[2*XLEN-1:XLEN];

    // Next-state selection, including when and what to capture into the result buffer
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_load_data  = '0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_req_bypass) begin
                        w_next_state = S_DONE;
                        w_load       = 1'b1;
                        w_load_data  = w_bypass_data;
                    end else if (w_req_is_mul) begin
                        w_next_state = S_MUL;
                    end else begin
                        w_next_state = S_DIV;
                    end
                end
            end
            S_MUL: begin
                if (mul_done) begin
                    // Done coinciding with flush: unit is already quiet, drop result
                    w_next_state = flush ? S_IDLE : S_DONE;
                    w_load       = !flush;
                    w_load_data  = w_mul_result;
                end else if (flush) begin
                    w_next_state = S_ABORT;
                end
            end
            S_DIV: begin
                if (div_done) begin
                    w_next_state = flush ? S_IDLE : S_DONE;
                    w_load       = !flush;
                    w_load_data  = w_div_result;
                end else if (flush) begin
                    w_next_state = S_ABORT;
                end
            end
            S_DONE: begin
                if (flush || resp_ready)
                    w_next_state = S_IDLE;
            end
            S_ABORT: begin
                // Keep the sub-unit running until it reports done, then discard
                if (w_op_is_mul ? mul_done : div_done)
                    w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // Operand latch on accept and result buffer capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_op        <= 4'd0;
            r_a         <= '0;
            r_b         <= '0;
            r_sa        <= 1'b0;
            r_sb        <= 1'b0;
            r_resp_data <= '0;
        end else begin
            if (w_accept) begin
                r_op <= req_op;
                r_a  <= req_a;
                r_b  <= req_b;
                r_sa <= w_req_sa;
                r_sb <= w_req_sb;
            end
            if (w_load)
                r_resp_data <= w_load_data;
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_DONE);
    assign resp_data  = r_resp_data;
    assign mul_valid  = (r_state == S_MUL) || ((r_state == S_ABORT) && w_op_is_mul);
    assign div_valid  = (r_state == S_DIV) || ((r_state == S_ABORT) && !w_op_is_mul);
    assign mul_a      = r_a;
    assign mul_b      = r_b;
    assign div_word   = w_op_div_word;
    assign div_a      = w_a_mag;
    assign div_b      = w_b_mag;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl
// Description : Scoreboard bench for muldiv_ctrl. Stimulus pushes the
//               hand-computed result into a queue; a monitor pops and compares
//               on every accepted response. Sub-units are driven directly.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl;
    localparam int XLEN = 64;
    localparam logic [XLEN-1:0] c_min  = 64'h8000_0000_0000_0000;
    localparam logic [XLEN-1:0] c_ones = 64'hFFFF_FFFF_FFFF_FFFF;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [3:0]          req_op = 4'd0;
    logic [XLEN-1:0]     req_a = '0;
    logic [XLEN-1:0]     req_b = '0;
    logic                flush = 1'b0;
    logic                resp_valid;
    logic                resp_ready = 1'b1;
    logic [XLEN-1:0]     resp_data;
    logic                mul_valid;
    logic [XLEN-1:0]     mul_a;
    logic [XLEN-1:0]     mul_b;
    logic                mul_done = 1'b0;
    logic [2*XLEN-1:0]   mul_c = '0;
    logic                div_valid;
    logic                div_word;
    logic [XLEN-1:0]     div_a;
    logic [XLEN-1:0]     div_b;
    logic                div_done = 1'b0;
    logic [2*XLEN-1:0]   div_c = '0;

    int errors = 0;
    int checks = 0;
    int transfers = 0;
    int t0;
    logic [XLEN-1:0] exp_q[$];

    muldiv_ctrl #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .flush(flush),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done), .mul_c(mul_c),
        .div_valid(div_valid), .div_word(div_word), .div_a(div_a), .div_b(div_b),
        .div_done(div_done), .div_c(div_c)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got timeout, expected event", name);
    endtask

    // Monitor: every accepted response is compared with the oldest expectation
    always @(negedge clk) begin
        if (reset && resp_valid && resp_ready && !flush) begin
            transfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: got 0x%h, expected no response", resp_data);
            end else begin
                check("resp_data", resp_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic send(input logic [3:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        int k = 0;
        while (!req_ready && k < 50) begin @(posedge clk); #1; k++; end
        if (!req_ready) timeout("req_ready_wait");
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic serve_mul(input int n, input logic [2*XLEN-1:0] c);
        int k = 0;
        while (!mul_valid && k < 20) begin @(posedge clk); #1; k++; end
        if (!mul_valid) timeout("mul_valid_wait");
        repeat (n - 1) begin @(posedge clk); #1; end
        mul_done = 1'b1; mul_c = c;
        @(posedge clk); #1;
        mul_done = 1'b0;
    endtask

    task automatic serve_div(input int n, input logic [XLEN-1:0] rem, input logic [XLEN-1:0] quo);
        int k = 0;
        while (!div_valid && k < 20) begin @(posedge clk); #1; k++; end
        if (!div_valid) timeout("div_valid_wait");
        repeat (n - 1) begin @(posedge clk); #1; end
        div_done = 1'b1; div_c = {rem, quo};
        @(posedge clk); #1;
        div_done = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (!(exp_q.size() == 0 && req_ready) && k < 50) begin @(posedge clk); #1; k++; end
        if (!(exp_q.size() == 0 && req_ready)) timeout("drain");
    endtask

    initial begin
        // Reset state
        #12;
        check("rst_req_ready",  64'(req_ready),  64'd1);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_data",  resp_data,       64'd0);
        check("rst_mul_valid",  64'(mul_valid),  64'd0);
        check("rst_div_valid",  64'(div_valid),  64'd0);
        check("rst_div_word",   64'(div_word),   64'd0);
        check("rst_operands",   mul_a | mul_b | div_a | div_b, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // DIV -7/2 -> -3 and REM -> -1, DIVU 7/2 -> 3
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
        send(4'd2, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        check("div_a_abs", div_a, 64'd7);
        check("div_b_abs", div_b, 64'd2);
        check("div_word_full", 64'(div_word), 64'd0);
        serve_div(3, 64'd1, 64'd3);
        drain();

        exp_q.push_back(c_ones);
        send(4'd4, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2);
        serve_div(2, 64'd1, 64'd3);
        drain();

        exp_q.push_back(64'd3);
        send(4'd3, 64'd7, 64'd2);
        check("divu_a", div_a, 64'd7);
        serve_div(1, 64'd1, 64'd3);
        drain();

        // MULW sign extension, MUL 3*5
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFE);
        send(4'd1, 64'h7FFF_FFFF, 64'd2);
        check("mul_valid_run", 64'(mul_valid), 64'd1);
        check("mul_a", mul_a, 64'h7FFF_FFFF);
        serve_mul(2, 128'h0000_0000_FFFF_FFFE);
        drain();

        exp_q.push_back(64'd15);
        send(4'd0, 64'd3, 64'd5);
        serve_mul(4, 128'd15);
        drain();

        // DIVW with junk upper bits: -20/3 -> -6
        exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFA);
        send(4'd6, 64'h1234_5678_FFFF_FFEC, 64'd3);
        check("divw_a_abs", div_a, 64'd20);
        check("divw_b", div_b, 64'd3);
        check("divw_word", 64'(div_word), 64'd1);
        serve_div(2, 64'd2, 64'd6);
        drain();

        // Illegal op -> 0
        exp_q.push_back(64'd0);
        send(4'd12, 64'd5, 64'd5);
        drain();

        // Bypass: DIV x/0 one cycle after accept, divider untouched
        exp_q.push_back(c_ones);
        send(4'd2, 64'd123, 64'd0);
        @(negedge clk);
        check("div0_latency", 64'(resp_valid), 64'd1);
        check("div0_no_div", 64'(div_valid), 64'd0);
        drain();

        exp_q.push_back(64'hFFFF_FFFF_8000_0005);
        send(4'd8, 64'h1_8000_0005, 64'd0);
        @(negedge clk);
        check("remw0_no_div", 64'(div_valid), 64'd0);
        drain();

        exp_q.push_back(c_min);
        send(4'd2, c_min, c_ones);
        @(negedge clk);
        check("ovf_no_div", 64'(div_valid), 64'd0);
        drain();

        exp_q.push_back(64'd0);
        send(4'd4, c_min, c_ones);
        drain();

        // Backpressure: result held stable for 5 cycles, single transfer
        resp_ready = 1'b0;
        t0 = transfers;
        exp_q.push_back(64'd14);
        send(4'd3, 64'd100, 64'd7);
        serve_div(2, 64'd2, 64'd14);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 64'(resp_valid), 64'd1);
            check("bp_data", resp_data, 64'd14);
            check("bp_req_ready", 64'(req_ready), 64'd0);
        end
        check("bp_no_transfer", 64'(transfers), 64'(t0));
        @(posedge clk); #1 resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_req_ready_after", 64'(req_ready), 64'd1);
        check("bp_valid_after", 64'(resp_valid), 64'd0);
        check("bp_one_transfer", 64'(transfers), 64'(t0 + 1));
        @(posedge clk); #1;

        // Flush three cycles into a divide
        send(4'd2, 64'd50, 64'd5);
        @(posedge clk); #1;
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_div_valid", 64'(div_valid), 64'd1);
            check("abort_resp_valid", 64'(resp_valid), 64'd0);
            check("abort_req_ready", 64'(req_ready), 64'd0);
        end
        @(posedge clk); #1 div_done = 1'b1; div_c = {64'd0, 64'd10};
        @(negedge clk);
        check("abort_div_valid_done", 64'(div_valid), 64'd1);
        @(posedge clk); #1 div_done = 1'b0;
        @(negedge clk);
        check("abort_req_ready_back", 64'(req_ready), 64'd1);
        check("abort_div_valid_off", 64'(div_valid), 64'd0);
        check("abort_no_resp", 64'(resp_valid), 64'd0);
        @(posedge clk); #1;
        exp_q.push_back(64'd3);
        send(4'd3, 64'd9, 64'd3);
        serve_div(2, 64'd0, 64'd3);
        drain();

        // Asynchronous reset during MUL
        send(4'd0, 64'd6, 64'd7);
        @(posedge clk); #1;
        @(posedge clk); #3 reset = 1'b0;
        #1;
        check("arst_mul_valid", 64'(mul_valid), 64'd0);
        check("arst_req_ready", 64'(req_ready), 64'd1);
        check("arst_resp_data", resp_data, 64'd0);
        check("arst_mul_a", mul_a, 64'd0);
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        // Flush in IDLE blocks acceptance
        req_op = 4'd0; req_a = 64'd2; req_b = 64'd2; req_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1 req_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        check("flush_idle_ready", 64'(req_ready), 64'd1);
        check("flush_idle_no_mul", 64'(mul_valid), 64'd0);
        @(posedge clk); #1;

        // Flush in DONE drops the result, with and without resp_ready
        resp_ready = 1'b0;
        send(4'd3, 64'd1, 64'd0);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_done_drop", 64'(resp_valid), 64'd0);
        check("flush_done_ready", 64'(req_ready), 64'd1);
        @(posedge clk); #1;
        t0 = transfers;
        send(4'd3, 64'd1, 64'd0);
        flush = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        check("flush_done_rdy_drop", 64'(resp_valid), 64'd0);
        check("flush_done_rdy_idle", 64'(req_ready), 64'd1);
        check("flush_done_no_xfer", 64'(transfers), 64'(t0));

        @(posedge clk); #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
